ifetch_unit: RTL
================

// Module: ifetch_unit
// PURPOSE
//  Instruction fetch stage upstream of the multi-cycle control unit. Holds the architectural PC,
//  fetches one 32-bit instruction per ifu_valid window over a req/gnt/rvalid instruction bus,
//  and presents a stable instr word plus a one-cycle ifu_finish pulse that advances the FSM.
//  PC is written back by the writeback/branch path via pc_we/pc_next.
// PARAMETERS
//  RESET_PC    64'h8000_0000  PC value loaded on reset
//  TIMEOUT     255            max cycles in WAIT before a fetch is declared failed (1..255)
//  NOP_INSTR   32'h0000_0013  word driven on instr at reset and after a failed fetch (addi x0,x0,0)
// PORTS
//  clk          in   1   clock, all state on posedge
//  rst          in   1   asynchronous, active-high reset
//  ifu_valid    in   1   controller is in fetch state; level, held until ifu_finish seen
//  ifu_finish   out  1   one-cycle pulse: instr/pc/fetch_err valid for this fetch
//  instr        out  32  fetched instruction, stable from ifu_finish until the next ifu_finish
//  pc           out  64  current PC (address of instr once ifu_finish has pulsed)
//  pc_we        in   1   PC write strobe from writeback/branch path
//  pc_next      in   64  new PC value, sampled when pc_we=1
//  fetch_err    out  1   last fetch failed (misaligned, bus error, timeout); valid with instr
//  ibus_req     out  1   bus request
//  ibus_addr    out  64  bus byte address, word aligned
//  ibus_gnt     in   1   bus accepted request this cycle
//  ibus_rvalid  in   1   response valid
//  ibus_rdata   in   32  response data
//  ibus_err     in   1   response error, qualified by ibus_rvalid
// BEHAVIOUR
//  Reset (async): state=IDLE, pc=RESET_PC, instr=NOP_INSTR, ifu_finish=0, fetch_err=0,
//    ibus_req=0, ibus_addr=0, timeout counter=0. Effective immediately, including mid-fetch.
//  FSM states IDLE, REQ, WAIT, DONE:
//   IDLE: ifu_valid=1 and pc[1:0]==0 -> REQ, latch ibus_addr<=pc.
//         ifu_valid=1 and pc[1:0]!=0 -> DONE with instr<=NOP_INSTR, fetch_err<=1, no bus access.
//         ifu_valid=0 -> stay.
//   REQ:  ibus_req=1, ibus_addr held constant until gnt. gnt=1 -> WAIT, counter<=0.
//         rvalid while in REQ is ignored.
//   WAIT: ibus_req=0. rvalid=1 -> DONE, instr<=ibus_err?NOP_INSTR:ibus_rdata, fetch_err<=ibus_err.
//         No rvalid: counter++. counter==TIMEOUT-1 -> DONE, instr<=NOP_INSTR, fetch_err<=1.
//   DONE: ifu_finish=1 for exactly this cycle -> IDLE unconditionally.
//  rvalid is legal no earlier than the cycle after gnt; rvalid arriving in IDLE/DONE (stale or
//    killed by reset) is dropped and changes nothing.
//  Minimum latency (zero-wait bus): ifu_valid seen in IDLE at T, req/gnt at T+1, rvalid at T+2,
//    ifu_finish at T+3.
//  pc_we: pc<=pc_next on the next edge in any state. An in-flight fetch keeps its latched
//    ibus_addr. pc_next is used from the next IDLE->REQ decision onward. pc never self-increments.
//  pc_we in the same cycle as the IDLE->REQ decision: the fetch uses the old pc, pc takes pc_next.
//  instr and fetch_err change only on the WAIT->DONE or IDLE->DONE transition. Between fetches
//    they hold, so downstream decode and register logic sees a stable word.
//  ifu_valid dropping before DONE (controller reset or abort) does not cancel the bus transaction.
//    The FSM completes it and pulses ifu_finish, which the controller ignores.
// TESTING
//  Reset, ifu_valid=1, bus gnt same cycle, rvalid next cycle with rdata=32'h00500093
//    -> ibus_addr=64'h8000_0000, ifu_finish at T+3, instr=32'h00500093, fetch_err=0.
//  gnt delayed 3 cycles, rvalid 5 cycles after gnt
//    -> ibus_req held high with ibus_addr constant for 4 cycles, exactly one ifu_finish pulse.
//  pc_we=1, pc_next=64'h8000_0102, then ifu_valid
//    -> no ibus_req, ifu_finish two cycles later, instr=32'h0000_0013, fetch_err=1.
//  rvalid with ibus_err=1 -> instr=NOP_INSTR, fetch_err=1. Next good fetch clears fetch_err.
//  TIMEOUT=4, gnt given, rvalid never arrives
//    -> ifu_finish with fetch_err=1 on the 4th WAIT-exit edge. A late rvalid in IDLE is ignored.
//  Assert rst during WAIT, then deliver rvalid
//    -> pc=RESET_PC, instr=NOP_INSTR, no ifu_finish.
//    pc_we during WAIT with pc_next=64'h8000_0040 -> current fetch keeps old addr, next uses 0x40.

Source files
------------

// File: rtl/ifetch_unit_if.sv
// Instruction bus bundle between the fetch unit (master) and memory (slave).
// Address/request flow out; grant and the response flow back.
interface ifetch_unit_if;
   logic        ibus_req;
   logic [63:0] ibus_addr;
   logic        ibus_gnt;
   logic        ibus_rvalid;
   logic [31:0] ibus_rdata;
   logic        ibus_err;

   modport master (
      output ibus_req,
      output ibus_addr,
      input  ibus_gnt,
      input  ibus_rvalid,
      input  ibus_rdata,
      input  ibus_err
   );

   modport slave (
      input  ibus_req,
      input  ibus_addr,
      output ibus_gnt,
      output ibus_rvalid,
      output ibus_rdata,
      output ibus_err
   );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per ifu_valid window
// over a req/gnt/rvalid bus and pulses ifu_finish when instr/fetch_err are valid.
module ifetch_unit #(
   parameter logic [63:0] RESET_PC  = 64'h8000_0000,
   parameter int unsigned TIMEOUT   = 255,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ifu_valid,
   output logic         ifu_finish,
   output logic [31:0]  instr,
   output logic [63:0]  pc,
   input  logic         pc_we,
   input  logic [63:0]  pc_next,
   output logic         fetch_err,
   ifetch_unit_if.master ibus
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DONE
   } state_e;

   localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] addr_q, addr_d;
   logic [31:0] instr_q, instr_d;
   logic        err_q, err_d;
   logic [7:0]  cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         addr_q  <= '0;
         instr_q <= NOP_INSTR;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_we ? pc_next : pc_q;
      addr_d  = addr_q;
      instr_d = instr_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (ifu_valid) begin
               if (pc_q[1:0] == 2'b00) begin
                  state_d = REQ;
                  addr_d  = pc_q;
               end else begin
                  state_d = DONE;
                  instr_d = NOP_INSTR;
                  err_d   = 1'b1;
               end
            end
         end
         REQ: begin
            if (ibus.ibus_gnt) begin
               state_d = WAIT;
               cnt_d   = '0;
            end
         end
         WAIT: begin
            if (ibus.ibus_rvalid) begin
               state_d = DONE;
               instr_d = ibus.ibus_err ? NOP_INSTR : ibus.ibus_rdata;
               err_d   = ibus.ibus_err;
            end else if (cnt_q == CntLast) begin
               state_d = DONE;
               instr_d = NOP_INSTR;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign ibus.ibus_req  = (state_q == REQ);
   assign ibus.ibus_addr = addr_q;
   assign ifu_finish     = (state_q == DONE);
   assign instr          = instr_q;
   assign pc             = pc_q;
   assign fetch_err      = err_q;

endmodule
